// File: rtl/bin_to_bcd_seq.sv
// bin_to_bcd_seq: sequential shift-and-add-3 binary-to-BCD converter with a start/busy/done handshake
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
);
    localparam int CW = $clog2(BIN_W + 1);
    localparam int SW = 4 * DIGITS;
    typedef enum logic {IDLE, CONV} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BIN_W-1:0] sh_q, sh_d;
    logic [SW-1:0]    scr_q, scr_d, adj;
    logic             ovf_q, ovf_d;
    logic             busy_q, busy_d, done_q, done_d, oflo_q, oflo_d;
    logic [SW-1:0]    bcd_q, bcd_d;
    always_comb begin
        adj = scr_q;
        for (int i = 0; i < DIGITS; i++)
            adj[4*i +: 4] = scr_q[4*i +: 4] >= 4'd5 ? scr_q[4*i +: 4] + 4'd3 : scr_q[4*i +: 4];
        state_d = state_q;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        scr_d   = scr_q;
        ovf_d   = ovf_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        bcd_d   = bcd_q;
        oflo_d  = oflo_q;
        if (state_q == IDLE) begin
            if (start) begin
                state_d = CONV;
                cnt_d   = '0;
                sh_d    = bin_in;
                scr_d   = '0;
                ovf_d   = 1'b0;
                busy_d  = 1'b1;
            end
        end else begin
            // a carry out of the top digit means the value reached 10^DIGITS
            cnt_d = cnt_q + 1'b1;
            sh_d  = sh_q << 1;
            scr_d = {adj[SW-2:0], sh_q[BIN_W-1]};
            ovf_d = ovf_q | adj[SW-1];
            if (cnt_q == CW'(BIN_W - 1)) begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                bcd_d   = scr_d;
                oflo_d  = ovf_d;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sh_q    <= '0;
            scr_q   <= '0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            bcd_q   <= '0;
            oflo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            scr_q   <= scr_d;
            ovf_q   <= ovf_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            bcd_q   <= bcd_d;
            oflo_q  <= oflo_d;
        end
    end
    assign busy     = busy_q;
    assign done     = done_q;
    assign bcd_out  = bcd_q;
    assign overflow = oflo_q;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// tb_bin_to_bcd_seq: directed and randomized checks of bin_to_bcd_seq against an arithmetic decimal model
module tb_bin_to_bcd_seq;
    logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, sel = 1'b0;
    logic [7:0]  bin_in = 8'd0;
    logic        busy3, done3, ovf3, busy2, done2, ovf2;
    logic [11:0] bcd3;
    logic [7:0]  bcd2;
    int          checks = 0, errors = 0;
    always #5 clk = ~clk;
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(3)) u3 (.clk(clk), .rst_n(rst_n), .start(start & !sel), .bin_in(bin_in),
        .busy(busy3), .done(done3), .bcd_out(bcd3), .overflow(ovf3));
    bin_to_bcd_seq #(.BIN_W(8), .DIGITS(2)) u2 (.clk(clk), .rst_n(rst_n), .start(start & sel), .bin_in(bin_in),
        .busy(busy2), .done(done2), .bcd_out(bcd2), .overflow(ovf2));
    wire        busy_m = sel ? busy2 : busy3;
    wire        done_m = sel ? done2 : done3;
    wire        ovf_m  = sel ? ovf2 : ovf3;
    wire [11:0] bcd_m  = sel ? {4'h0, bcd2} : bcd3;
    function automatic logic [11:0] ref_bcd(input int v, input int digits);
        logic [11:0] r = '0;
        int p = 1;
        for (int d = 0; d < digits; d++) begin
            r[4*d +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction
    function automatic logic ref_ovf(input int v, input int digits);
        int p = 1;
        for (int d = 0; d < digits; d++) p = p * 10;
        return v >= p;
    endfunction
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic kick(input logic [7:0] v);
        @(negedge clk);
        bin_in = v;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
    endtask
    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_m && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask
    task automatic count_dones(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (done_m) n++;
        end
    endtask
    task automatic run(input logic [7:0] v);
        int lat;
        int dg = sel ? 2 : 3;
        kick(v);
        chk("busy_after_start", busy_m, 1);
        wait_done(lat);
        chk("latency", lat, 8);
        chk("bcd", bcd_m, ref_bcd(v, dg));
        chk("overflow", ovf_m, ref_ovf(v, dg));
        @(negedge clk);
        chk("done_one_cycle", done_m, 0);
        chk("busy_idle", busy_m, 0);
    endtask
    initial begin
        int lat, n;
        logic [7:0] perm [256];
        repeat (2) @(negedge clk);
        chk("reset_busy", busy3, 0);
        chk("reset_done", done3, 0);
        chk("reset_bcd", bcd3, 0);
        chk("reset_ovf", ovf3, 0);
        rst_n = 1'b1;
        run(8'd0);
        run(8'd255);
        run(8'd99);
        run(8'd10);
        kick(8'd123);
        repeat (4) begin
            start  = 1'b1;
            bin_in = 8'd7;
            @(negedge clk);
        end
        start = 1'b0;
        wait_done(lat);
        chk("ignored_start_latency", lat, 4);
        chk("ignored_start_bcd", bcd3, 12'h123);
        count_dones(12, n);
        chk("ignored_start_no_extra_done", n, 0);
        kick(8'd42);
        wait_done(lat);
        chk("b2b_first_bcd", bcd3, 12'h042);
        bin_in = 8'd200;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("b2b_done_drops", done3, 0);
        chk("b2b_busy_rises", busy3, 1);
        chk("b2b_bcd_held", bcd3, 12'h042);
        wait_done(lat);
        chk("b2b_latency", lat, 8);
        chk("b2b_second_bcd", bcd3, 12'h200);
        kick(8'd77);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("abort_busy", busy3, 0);
        chk("abort_done", done3, 0);
        chk("abort_bcd", bcd3, 0);
        rst_n = 1'b1;
        count_dones(12, n);
        chk("abort_no_done", n, 0);
        run(8'd77);
        repeat (40) run(8'($urandom_range(0, 255)));
        sel = 1'b1;
        run(8'd100);
        chk("d2_100_ovf", ovf2, 1);
        chk("d2_100_bcd", bcd2, 8'h00);
        run(8'd57);
        chk("d2_57_ovf", ovf2, 0);
        chk("d2_57_bcd", bcd2, 8'h57);
        for (int i = 0; i < 256; i++) perm[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            int j = int'($urandom_range(0, i));
            logic [7:0] t = perm[i];
            perm[i] = perm[j];
            perm[j] = t;
        end
        for (int i = 0; i < 256; i++) run(perm[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
